// File: rtl/instruction_prefetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle-latency instruction memory and
// queues returned words with their PC for decode; redirects flush everything in flight.
module instruction_prefetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [31:0]        dec_instr,
    output logic [31:0]        dec_pc
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] tag;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] count;
    logic [31:0] instr_q [FIFO_DEPTH];
    logic [31:0] pc_q    [FIFO_DEPTH];
    logic        issue;
    logic        push;
    logic        pop;
    logic        empty;
    logic        full;
    logic        credit;

    always_comb begin
        count  = wr_ptr - rd_ptr;
        empty  = (count == '0);
        full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        // An outstanding read reserves a FIFO slot, so a push can never find the FIFO full.
        credit = ({1'b0, count} + {{(PW+1){1'b0}}, state == WAIT}) < (PW+2)'(FIFO_DEPTH);

        issue      = rst && !redirect_valid && credit;
        push       = rst && !redirect_valid && (state == WAIT);
        dec_valid  = rst && !empty;
        pop        = dec_valid && dec_ready;
        imem_rd_en = issue;
        imem_addr  = pc[IMEM_AW+1:2];
        dec_instr  = dec_valid ? instr_q[rd_ptr[PW-1:0]] : '0;
        dec_pc     = dec_valid ? pc_q[rd_ptr[PW-1:0]] : RESET_PC;
        state_next = issue ? WAIT : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            tag    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect_valid) begin
            state  <= IDLE;
            pc     <= redirect_pc & ~32'h3;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                pc  <= pc + 32'd4;
                tag <= pc;
            end
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr[PW-1:0]] <= imem_rdata;
            pc_q[wr_ptr[PW-1:0]]    <= tag;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed scenarios plus random redirects/resets/back-pressure,
// checked by a monitor against a sequential-fetch reference model and a directed expectation queue.
module tb_instruction_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    localparam int S_VALID = 0;
    localparam int S_PC    = 1;
    localparam int S_EN    = 2;
    localparam int S_INSTR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;

    instruction_prefetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .IMEM_AW   (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem_word(imem_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } dir_t;

    dir_t        dir_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc   = RESET_PC;
    logic [31:0] fetch_pc = RESET_PC;
    int          held     = 0;
    int          pops     = 0;
    int          rnd_start_pops = 0;
    int          checks   = 0;
    int          errors   = 0;
    bit          done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            S_VALID: return "dec_valid";
            S_PC:    return "dec_pc_directed";
            S_EN:    return "imem_rd_en";
            default: return "dec_instr_directed";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_VALID: return 32'(dec_valid);
            S_PC:    return dec_pc;
            S_EN:    return 32'(imem_rd_en);
            default: return dec_instr;
        endcase
    endfunction

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // After a flush the fetch and the presented stream both restart at the aligned target.
    task automatic restart(input logic [31:0] target);
        exp_q.delete();
        exp_pc   = target & ~32'h3;
        fetch_pc = target & ~32'h3;
        held     = 0;
        refill();
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int          i;
        if (rst !== 1'b1 || redirect_valid) begin
            check("rd_en_quiet", 32'(imem_rd_en), 32'd0);
        end else if (imem_rd_en) begin
            check("issue_addr", 32'(imem_addr), 32'(fetch_pc[AW+1:2]));
            check("issue_credit", 32'(held >= DEPTH), 32'd0);
            fetch_pc = fetch_pc + 32'd4;
            held++;
        end else begin
            check("stall_only_when_full", 32'(held), 32'(DEPTH));
        end

        if (dec_valid === 1'b1 && dec_ready) begin
            pops++;
            held--;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow actual_pc=%h required=none", dec_pc);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_instr", dec_instr, mem_word(e[AW+1:2]));
            end
        end else if (dec_valid !== 1'b1) begin
            check("empty_instr", dec_instr, 32'd0);
        end

        i = 0;
        while (i < dir_q.size()) begin
            if (dir_q[i].cyc == cyc) begin
                check(sig_name(dir_q[i].sig), sig_val(dir_q[i].sig), dir_q[i].val);
                dir_q.delete(i);
            end else begin
                i++;
            end
        end

        if (rst !== 1'b1) restart(RESET_PC);
        else if (redirect_valid) restart(redirect_pc);
        refill();

        if (done) begin
            check("directed_pending", 32'(dir_q.size()), 32'd0);
            check("random_progress", 32'(pops - rnd_start_pops >= 100), 32'd1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic drive(input logic r, input logic rv, input logic [31:0] t,
                         input logic rdy, input int n);
        for (int k = 0; k < n; k++) begin
            rst            = r;
            redirect_valid = rv;
            redirect_pc    = t;
            dec_ready      = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic post(input int off, input int sig, input logic [31:0] v);
        dir_q.push_back('{cyc + off, sig, v});
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset outputs
        post(0, S_EN, 0); post(0, S_VALID, 0); post(0, S_PC, RESET_PC); post(0, S_INSTR, 0);
        post(2, S_VALID, 0); post(2, S_PC, RESET_PC);
        drive(0, 0, '0, 1, 3);

        // 1: release, streaming one word per cycle
        post(0, S_EN, 1); post(0, S_VALID, 0); post(1, S_VALID, 0);
        for (int k = 0; k < 6; k++) begin
            post(2 + k, S_VALID, 1);
            post(2 + k, S_PC, 32'(4 * k));
            post(2 + k, S_INSTR, 32'h1000_0000 + 32'(k));
        end
        drive(1, 0, '0, 1, 8);

        // 2: back-pressure fills the FIFO, then drains without a gap
        drive(0, 0, '0, 0, 1);
        for (int k = 0; k < 10; k++) post(k, S_EN, (k < 4) ? 32'd1 : 32'd0);
        post(5, S_PC, 0); post(9, S_PC, 0); post(9, S_VALID, 1);
        drive(1, 0, '0, 0, 10);
        for (int k = 0; k < 5; k++) begin
            post(k, S_VALID, 1);
            post(k, S_PC, 32'(4 * k));
        end
        post(1, S_EN, 1);
        drive(1, 0, '0, 1, 5);

        // 3: redirect with 3 queued and one read in flight
        drive(0, 0, '0, 0, 1);
        drive(1, 0, '0, 0, 4);
        post(0, S_VALID, 1); post(0, S_PC, 0); post(0, S_EN, 0);
        drive(1, 1, 32'h0000_0102, 0, 1);
        post(0, S_VALID, 0); post(0, S_EN, 1); post(1, S_VALID, 0);
        post(2, S_VALID, 1); post(2, S_PC, 32'h0000_0100);
        drive(1, 0, '0, 1, 6);

        // 4: redirect near the top of the address space, PC wraps
        drive(1, 1, 32'hFFFF_FFF8, 1, 1);
        post(0, S_EN, 1);
        post(2, S_PC, 32'hFFFF_FFF8); post(3, S_PC, 32'hFFFF_FFFC); post(4, S_PC, 32'h0);
        post(2, S_VALID, 1); post(3, S_VALID, 1); post(4, S_VALID, 1);
        drive(1, 0, '0, 1, 6);

        // 5: reset mid-stream with entries queued
        drive(1, 0, '0, 0, 1);
        post(0, S_VALID, 0); post(0, S_EN, 0); post(0, S_PC, RESET_PC); post(0, S_INSTR, 0);
        drive(0, 0, '0, 0, 1);
        post(0, S_VALID, 0); post(0, S_EN, 1); post(1, S_VALID, 0);
        post(2, S_VALID, 1); post(2, S_PC, RESET_PC);
        drive(1, 0, '0, 1, 5);

        // 6: back-to-back redirects, later target wins
        drive(1, 1, 32'h0000_0040, 1, 1);
        post(0, S_VALID, 0); post(0, S_EN, 0);
        drive(1, 1, 32'h0000_0080, 1, 1);
        post(0, S_VALID, 0); post(0, S_EN, 1); post(1, S_VALID, 0);
        post(2, S_VALID, 1); post(2, S_PC, 32'h0000_0080);
        drive(1, 0, '0, 1, 6);

        // random back-pressure, redirects and resets
        rnd_start_pops = pops;
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(63) != 0), ($urandom_range(15) == 0), $urandom,
                  ($urandom_range(3) != 0), 1);
        end
        drive(1, 0, '0, 1, 4);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
